// File: rtl/ps2_rx_fifo_if.sv
// Output word stream of the PS/2 receiver: FIFO head word with valid/ready.
interface ps2_rx_fifo_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: oversampled, synchronised and glitch-filtered
// lines, frame decode with parity/framing/timeout checks, small FWFT FIFO out.
module ps2_rx_fifo #(
  parameter int unsigned DATA_BITS      = 8,
  parameter int unsigned PARITY_MODE    = 1,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000,
  parameter int unsigned FIFO_DEPTH     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps2_clk_i,
  input  logic             ps2_d_i,
  ps2_rx_fifo_if.master    m_if,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             overflow_o,
  output logic             busy_o
);

  localparam int unsigned FCW = $clog2(FILTER_LEN);
  localparam int unsigned BCW = $clog2(DATA_BITS);
  localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned PW  = AW + 1;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_e;

  // Conditioning registers
  logic           clk_s1_q, clk_s2_q, d_s1_q, d_s2_q;
  logic           clk_filt_q, clk_filt_d, d_filt_q, d_filt_d;
  logic [FCW-1:0] clk_cnt_q, clk_cnt_d, d_cnt_q, d_cnt_d;
  logic           sample_c;

  // Frame decoder registers
  state_e               state_q, state_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [TCW-1:0]       tmo_q, tmo_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic                 par_ok_c, push_c;

  // FIFO registers
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic                 full_c, empty_c, pop_c, wr_en_c;

  // Filter: output follows the synchronised input only after FILTER_LEN equal samples
  always_comb begin
    clk_filt_d = clk_filt_q;
    clk_cnt_d  = '0;
    d_filt_d   = d_filt_q;
    d_cnt_d    = '0;
    if (clk_s2_q != clk_filt_q) begin
      if (clk_cnt_q == FCW'(FILTER_LEN - 1)) clk_filt_d = clk_s2_q;
      else                                   clk_cnt_d  = clk_cnt_q + FCW'(1);
    end
    if (d_s2_q != d_filt_q) begin
      if (d_cnt_q == FCW'(FILTER_LEN - 1)) d_filt_d = d_s2_q;
      else                                 d_cnt_d  = d_cnt_q + FCW'(1);
    end
  end

  // Sample event is the cycle in which the filtered clock commits to 0
  assign sample_c = clk_filt_q & ~clk_filt_d;

  // Two-flop synchronisers and filter state
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      d_s1_q     <= 1'b1;
      d_s2_q     <= 1'b1;
      clk_filt_q <= 1'b1;
      d_filt_q   <= 1'b1;
      clk_cnt_q  <= '0;
      d_cnt_q    <= '0;
    end else begin
      clk_s1_q   <= ps2_clk_i;
      clk_s2_q   <= clk_s1_q;
      d_s1_q     <= ps2_d_i;
      d_s2_q     <= d_s1_q;
      clk_filt_q <= clk_filt_d;
      d_filt_q   <= d_filt_d;
      clk_cnt_q  <= clk_cnt_d;
      d_cnt_q    <= d_cnt_d;
    end
  end

  // Parity check against the received payload
  always_comb begin
    par_ok_c = 1'b1;
    if (PARITY_MODE == 1)      par_ok_c = (^shift_q) ^ par_q;
    else if (PARITY_MODE == 2) par_ok_c = ~((^shift_q) ^ par_q);
  end

  // Frame decoder next state, timeout and outcome pulses
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    tmo_d     = '0;
    perr_d    = 1'b0;
    ferr_d    = 1'b0;
    push_c    = 1'b0;

    if (state_q != ST_IDLE && !sample_c) tmo_d = tmo_q + TCW'(1);

    case (state_q)
      ST_IDLE: begin
        if (sample_c && !d_filt_q) begin
          state_d   = ST_DATA;
          bit_cnt_d = '0;
        end
      end
      ST_DATA: begin
        if (sample_c) begin
          shift_d   = {d_filt_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + BCW'(1);
          if (bit_cnt_q == BCW'(DATA_BITS - 1))
            state_d = (PARITY_MODE == 0) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (sample_c) begin
          par_d   = d_filt_q;
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (sample_c) begin
          state_d = ST_IDLE;
          if (!d_filt_q)     ferr_d = 1'b1;
          else if (!par_ok_c) perr_d = 1'b1;
          else               push_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line stalled mid-frame: abandon the frame
    if (state_q != ST_IDLE && !sample_c && tmo_q == TCW'(TIMEOUT_CYCLES - 1)) begin
      state_d = ST_IDLE;
      tmo_d   = '0;
      ferr_d  = 1'b1;
    end
  end

  // Frame decoder state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      tmo_q     <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      tmo_q     <= tmo_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      ovf_q     <= ovf_d;
    end
  end

  // FIFO status; a pop in the same cycle frees a slot for a push into a full FIFO
  always_comb begin
    empty_c = (wr_ptr_q == rd_ptr_q);
    full_c  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop_c   = !empty_c && m_if.m_ready;
    wr_en_c = push_c && (!full_c || pop_c);
    ovf_d   = push_c && full_c && !pop_c;
  end

  // FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en_c) begin
        mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
        wr_ptr_q                <= wr_ptr_q + PW'(1);
      end
      if (pop_c) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  assign m_if.m_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign m_if.m_valid = !empty_c;
  assign parity_err_o = perr_q;
  assign frame_err_o  = ferr_q;
  assign overflow_o   = ovf_q;
  assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
- Parametrised next-generation PS/2 device-to-host receiver.
- Runs entirely on the system clock and oversamples the raw PS/2 clock and data lines.
- Synchronises and glitch-filters both lines, decodes start/data/parity/stop frames, and detects parity, framing and timeout errors.
- Buffers good words in a small FIFO with a valid/ready output for the keyboard/mouse decode logic.

Parameters:
- DATA_BITS, 8: payload bits per frame, LSB first.
- PARITY_MODE, 1: 0 = no parity bit, 1 = odd, 2 = even.
- FILTER_LEN, 8: consecutive identical samples needed before the filtered clock or data changes (>=2).
- TIMEOUT_CYCLES, 200000: max clk cycles between PS/2 clock falling edges inside a frame (2 ms at 100 MHz).
- FIFO_DEPTH, 4: output buffer depth in words; power of two, >=2.

Ports:
- clk, input, 1: system clock, 100 MHz.
- rst, input, 1: reset, synchronous, active-high. One clock; reset is synchronous and active-high.
- ps2_clk, input, 1: raw PS/2 clock line, asynchronous.
- ps2_d, input, 1: raw PS/2 data line, asynchronous.
- m_data, output, DATA_BITS: FIFO head word.
- m_valid, output, 1: FIFO non-empty.
- m_ready, input, 1: consumer accepts m_data this cycle.
- parity_err, output, 1: one-cycle pulse; frame dropped for bad parity.
- frame_err, output, 1: one-cycle pulse; frame dropped for stop bit = 0 or timeout.
- overflow, output, 1: one-cycle pulse; good word dropped because the FIFO was full.
- busy, output, 1: high while the FSM is not in IDLE.

Behaviour:
- Reset: m_valid, parity_err, frame_err, overflow and busy are 0; m_data is 0; FIFO is empty; FSM is in IDLE; filtered clock and data are 1; counters are 0. Reset mid-frame discards the partial frame and raises no error pulse.
- Input conditioning: each input passes through a 2-flop synchroniser. A filter stage updates its output only after FILTER_LEN consecutive equal synchronised samples.
- Sample event: a filtered-clock 1->0 transition. On that cycle the filtered data is sampled. Edge-to-sample latency is 2 + FILTER_LEN clk cycles after the raw edge.
- FSM IDLE: sample = 0 -> DATA, bit counter cleared. Sample = 1 -> stay in IDLE, no error.
- FSM DATA: shift right, with the new bit entering at the MSB, so the payload ends LSB-aligned. After DATA_BITS samples go to PARITY, or to STOP if PARITY_MODE = 0.
- FSM PARITY: store the parity bit. Odd mode: the check passes when (XOR of data) XOR (parity) = 1. Even mode: the check passes when it = 0. Then go to STOP.
- FSM STOP: on the sample event return to IDLE. Outcome priority:
  - Stop bit = 0: frame_err pulse.
  - Stop bit = 1 and parity check fails: parity_err pulse.
  - Stop bit = 1 and parity check passes: push the word.
  - parity_err and frame_err never pulse together.
- Timeout: a counter clears on every sample event and counts up while not in IDLE. When it reaches TIMEOUT_CYCLES: return to IDLE, pulse frame_err, discard the frame. The counter is held at 0 in IDLE.
- FIFO behaviour:
  - First-word-fall-through: m_data shows the head word whenever m_valid = 1; contents are don't-care when empty.
  - Pop occurs when m_valid && m_ready.
  - A push lands in the cycle after the STOP sample, so the word is visible on m_valid 1 cycle after the stop-bit sample event.
- FIFO full handling: a push is accepted if the FIFO is not full, or if a pop occurs in the same cycle. Otherwise the word is dropped and overflow pulses.
- FIFO empty handling: a simultaneous push and pop on an empty FIFO is impossible (m_valid = 0), so the push simply lands.
- Pointers: log2(FIFO_DEPTH)+1 bits; they wrap naturally.
- Word order is preserved.
- m_ready while m_valid = 0 has no effect.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0), odd parity bit 0, stop 1, bit period 40 us -> m_valid = 1 with m_data = 0x1C, one cycle after the stop sample; no error pulses; busy returns to 0.
- Same frame with parity bit 1 -> single parity_err pulse; m_valid stays 0. Frame 0xF0 with stop bit 0 -> single frame_err pulse, no push.
- 3-cycle low glitch on ps2_clk (FILTER_LEN = 8) while in IDLE and while mid-frame -> no sample event, FSM state and bit counter unchanged; a following clean frame 0x5A is received correctly.
- Start bit plus 4 data bits, then the clock stays high -> frame_err pulses exactly TIMEOUT_CYCLES after the last sample event; busy goes to 0; the next frame 0x29 is received correctly.
- m_ready = 0, five good frames 0x01..0x05, FIFO_DEPTH = 4 -> m_valid = 1 after the first, one overflow pulse at the fifth; raising m_ready drains 0x01, 0x02, 0x03, 0x04, then m_valid = 0. Full FIFO with push and pop in the same cycle -> no overflow.
- rst asserted for 1 cycle after 5 data bits of a frame -> busy and all pulses 0, FIFO empty; the next full frame 0xE0 is received correctly.
